// File: rtl/accumulator_mc.sv
// accumulator_mc: multi-channel complex pulse integrator.
// Each PRI is captured into a per-lane DEPTH x AW memory through a fixed
// read-modify-write pipeline. The first PRI of an integration (trig&trig_int)
// overwrites the memory and, if a prior integration exists, streams the old
// words out as a scaled dump; later PRIs (trig only) accumulate with
// saturation. Mode 0 integrates I/Q coherently, mode 1 integrates power.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   trig, trig_int      PRI start strobe and new-integration qualifier
//   len, mode, shift    integration settings, latched on trig&trig_int
//   din_I, din_Q        NCH packed signed samples, channel c at [c*DW +: DW]
//   dout_I, dout_Q      NCH packed scaled dump words, same packing
//   dout_vld, dout_last dump beat valid / final dump beat
//   busy                capture or pipeline drain in progress
//   ovr_err, sat        sticky: trig while busy / accumulator clipped
module accumulator_mc #(
    parameter int NCH   = 1,
    parameter int DW    = 16,
    parameter int AW    = 24,
    parameter int DEPTH = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trig,
    input  logic                      trig_int,
    input  logic [$clog2(DEPTH):0]    len,
    input  logic                      mode,
    input  logic [$clog2(AW)-1:0]     shift,
    input  logic [NCH*DW-1:0]         din_I,
    input  logic [NCH*DW-1:0]         din_Q,
    output logic [NCH*DW-1:0]         dout_I,
    output logic [NCH*DW-1:0]         dout_Q,
    output logic                      dout_vld,
    output logic                      dout_last,
    output logic                      busy,
    output logic                      ovr_err,
    output logic                      sat
);

    localparam int LW  = $clog2(DEPTH) + 1;
    localparam int ADW = $clog2(DEPTH);
    localparam int SW  = $clog2(AW);
    localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

    localparam logic signed [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [AW-1:0] DMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] DMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic {S_IDLE, S_CAPTURE} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   cnt_q, total_q;
    logic [LW-1:0]   cur_len, old_len, len_eff;
    logic            cur_mode;
    logic [SW-1:0]   cur_shift, old_shift;
    logic            primed, dump_act, first_pri;
    logic            accept;

    logic            p1_v, p1_wr, p1_dump, p1_last;
    logic [ADW-1:0]  p1_addr;
    logic            p2_v, p2_wr, p2_dump, p2_last;
    logic [ADW-1:0]  p2_addr;
    logic            d1_v, d1_last, d2_v, d2_last;
    logic            we;
    logic [NCH-1:0]  sat_hit;

    function automatic logic [DW-1:0] clamp_dw(input logic signed [AW-1:0] v);
        if (v > DMAX)
            return DMAX[DW-1:0];
        else if (v < DMIN)
            return DMIN[DW-1:0];
        else
            return v[DW-1:0];
    endfunction

    assign len_eff = (len == '0 || len > LEN_MAX) ? LEN_MAX : len;
    assign busy    = (state_q == S_CAPTURE) | p1_v | p2_v;
    assign accept  = trig & ~busy & (trig_int | primed);
    // Reset must win over a write-back already sitting in the last stage.
    assign we      = p2_v & p2_wr & rst;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_CAPTURE;
            S_CAPTURE: if (cnt_q == total_q - LW'(1)) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            total_q   <= LEN_MAX;
            cur_len   <= LEN_MAX;
            cur_mode  <= 1'b0;
            cur_shift <= '0;
            old_len   <= LEN_MAX;
            old_shift <= '0;
            primed    <= 1'b0;
            dump_act  <= 1'b0;
            first_pri <= 1'b0;
            ovr_err   <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (trig && busy)
                ovr_err <= 1'b1;
            if (|sat_hit)
                sat <= 1'b1;
            if (accept) begin
                cnt_q <= '0;
                if (trig_int) begin
                    cur_len   <= len_eff;
                    cur_mode  <= mode;
                    cur_shift <= shift;
                    old_len   <= cur_len;
                    old_shift <= cur_shift;
                    primed    <= 1'b1;
                    dump_act  <= primed;
                    first_pri <= 1'b1;
                    // Run long enough to finish both the new capture and the old dump.
                    total_q   <= (primed && (cur_len > len_eff)) ? cur_len : len_eff;
                end else begin
                    dump_act  <= 1'b0;
                    first_pri <= 1'b0;
                    total_q   <= cur_len;
                end
            end else if (state_q == S_CAPTURE) begin
                cnt_q <= cnt_q + LW'(1);
            end
        end
    end

    // Shared pipeline control: issue -> p1 (read) -> p2 (term) -> write-back,
    // then d1 (shift) -> d2 (clamp) -> dout register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p1_v <= 1'b0; p1_wr <= 1'b0; p1_dump <= 1'b0; p1_last <= 1'b0; p1_addr <= '0;
            p2_v <= 1'b0; p2_wr <= 1'b0; p2_dump <= 1'b0; p2_last <= 1'b0; p2_addr <= '0;
            d1_v <= 1'b0; d1_last <= 1'b0;
            d2_v <= 1'b0; d2_last <= 1'b0;
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
        end else begin
            p1_v    <= (state_q == S_CAPTURE);
            p1_addr <= cnt_q[ADW-1:0];
            p1_wr   <= (cnt_q < cur_len);
            p1_dump <= dump_act && (cnt_q < old_len);
            p1_last <= (cnt_q == old_len - LW'(1));
            p2_v    <= p1_v;
            p2_addr <= p1_addr;
            p2_wr   <= p1_wr;
            p2_dump <= p1_dump;
            p2_last <= p1_last;
            d1_v    <= p2_v && p2_dump;
            d1_last <= p2_v && p2_dump && p2_last;
            d2_v    <= d1_v;
            d2_last <= d1_last;
            dout_vld  <= d2_v;
            dout_last <= d2_last;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : gen_ch
        logic signed [AW-1:0] mem_i [DEPTH];
        logic signed [AW-1:0] mem_q [DEPTH];
        logic signed [DW-1:0] s1_i, s1_q, d2_i, d2_q, o_i, o_q;
        logic signed [AW-1:0] rd1_i, rd1_q, rd2_i, rd2_q;
        logic signed [AW-1:0] term_i, term_q, d1_i, d1_q;
        logic signed [AW-1:0] tc_i, tc_q, wv_i, wv_q;
        logic signed [2*DW:0] pw;
        logic signed [AW:0]   sum_i, sum_q;
        logic                 clip_i, clip_q;

        always_comb begin
            pw    = (2*DW+1)'((2*DW)'(s1_i) * (2*DW)'(s1_i))
                  + (2*DW+1)'((2*DW)'(s1_q) * (2*DW)'(s1_q));
            tc_i  = cur_mode ? AW'(pw >>> DW) : AW'(s1_i);
            tc_q  = cur_mode ? '0 : AW'(s1_q);
            sum_i = (AW+1)'(rd2_i) + (AW+1)'(term_i);
            sum_q = (AW+1)'(rd2_q) + (AW+1)'(term_q);
            clip_i = sum_i[AW] ^ sum_i[AW-1];
            clip_q = sum_q[AW] ^ sum_q[AW-1];
            wv_i = first_pri ? term_i : (clip_i ? (sum_i[AW] ? AMIN : AMAX) : sum_i[AW-1:0]);
            wv_q = first_pri ? term_q : (clip_q ? (sum_q[AW] ? AMIN : AMAX) : sum_q[AW-1:0]);
        end

        assign sat_hit[c] = we & ~first_pri & (clip_i | clip_q);

        always_ff @(posedge clk) begin
            if (we) begin
                mem_i[p2_addr] <= wv_i;
                mem_q[p2_addr] <= wv_q;
            end
            rd1_i <= mem_i[cnt_q[ADW-1:0]];
            rd1_q <= mem_q[cnt_q[ADW-1:0]];
        end

        always_ff @(posedge clk) begin
            s1_i   <= din_I[c*DW +: DW];
            s1_q   <= din_Q[c*DW +: DW];
            term_i <= tc_i;
            term_q <= tc_q;
            rd2_i  <= rd1_i;
            rd2_q  <= rd1_q;
            d1_i   <= rd2_i >>> old_shift;
            d1_q   <= rd2_q >>> old_shift;
            d2_i   <= clamp_dw(d1_i);
            d2_q   <= clamp_dw(d1_q);
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                o_i <= '0;
                o_q <= '0;
            end else if (d2_v) begin
                o_i <= d2_i;
                o_q <= d2_q;
            end
        end

        assign dout_I[c*DW +: DW] = o_i;
        assign dout_Q[c*DW +: DW] = o_q;
    end

endmodule
